m_req_arb2: RTL and testbench

Two-requester packet arbiter for the MIC interconnect. Shares one request channel between two requesters, e.g. two memory testers or a CPU and a DMA engine, and steers the single response channel back to the right requester using the SRC_ID field of each response header. Grants last for a whole packet, so a packet is never interleaved with another. Sits between the requesters and one interconnect port.

---
 rtl/m_req_arb2.sv | 204 ++++++++++++++++++++
 tb/tb_m_req_arb2.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_req_arb2.sv
// m_req_arb2 -- two-requester packet arbiter for the MIC interconnect.
//
// Purpose:
//   Shares one request channel between two requesters. A grant lasts for a
//   whole packet, so packets are never interleaved. Each response packet is
//   steered back to its owner using the source ID in its header beat,
//   RI_TDATA[55:48]. The data paths are purely combinational.
//
// Ports:
//   clk, reset                   clock (rising edge), asynchronous active-low reset
//   I0_T* / I1_T*                request inputs from requester 0 / 1
//   O_T*                         merged request output
//   RI_T*                        response input
//   R0_T* / R1_T*                response outputs to requester 0 / 1
//   bad_id                       sticky flag: a response header matched neither ID
//
// Configuration macro:
//   ARB_FIXED_PRIORITY_EN  when defined, port 0 always wins a tie in ARB_IDLE
//                          and rr stays at 0; otherwise ties go round-robin.

module m_req_arb2 #(
    parameter logic [7:0] SRC_ID0 = 8'h00,
    parameter logic [7:0] SRC_ID1 = 8'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        I0_TVALID,
    output logic        I0_TREADY,
    input  logic [63:0] I0_TDATA,
    input  logic        I0_TLAST,
    input  logic        I1_TVALID,
    output logic        I1_TREADY,
    input  logic [63:0] I1_TDATA,
    input  logic        I1_TLAST,
    output logic        O_TVALID,
    input  logic        O_TREADY,
    output logic [63:0] O_TDATA,
    output logic        O_TLAST,
    input  logic        RI_TVALID,
    output logic        RI_TREADY,
    input  logic [63:0] RI_TDATA,
    input  logic        RI_TLAST,
    output logic        R0_TVALID,
    input  logic        R0_TREADY,
    output logic [63:0] R0_TDATA,
    output logic        R0_TLAST,
    output logic        R1_TVALID,
    input  logic        R1_TREADY,
    output logic [63:0] R1_TDATA,
    output logic        R1_TLAST,
    output logic        bad_id
);

    localparam logic       ARB_IDLE = 1'b0;
    localparam logic       ARB_BUSY = 1'b1;
    localparam logic [1:0] RSP_HDR  = 2'd0;
    localparam logic [1:0] RSP_PASS = 2'd1;
    localparam logic [1:0] RSP_DROP = 2'd2;

    logic       arb_q, arb_d;
    logic       grant_q, grant_d;
    logic       rr_q, rr_d;
    logic       winner;
    logic [1:0] rsp_q, rsp_d;
    logic       rsel_q, rsel_d;
    logic       bad_q, bad_d;
    logic [7:0] hdr_id;
    logic       hit0, hit1;
    logic       route_en;   // 0: response beat is sunk, 1: routed to route_sel
    logic       route_sel;
    logic       rsp_hs;

    // ------------------------------------------------------------------
    // Request arbiter
    // ------------------------------------------------------------------
    always_comb begin
`ifdef ARB_FIXED_PRIORITY_EN
        winner = ~I0_TVALID;
`else
        // The pointed-to port wins if it is requesting, else the other one.
        if (rr_q) winner = I1_TVALID ? 1'b1 : 1'b0;
        else      winner = I0_TVALID ? 1'b0 : 1'b1;
`endif
    end

    always_comb begin
        O_TVALID  = 1'b0;
        O_TDATA   = '0;
        O_TLAST   = 1'b0;
        I0_TREADY = 1'b0;
        I1_TREADY = 1'b0;
        if (arb_q == ARB_BUSY) begin
            if (grant_q) begin
                O_TVALID  = I1_TVALID;
                O_TDATA   = I1_TDATA;
                O_TLAST   = I1_TLAST;
                I1_TREADY = O_TREADY;
            end else begin
                O_TVALID  = I0_TVALID;
                O_TDATA   = I0_TDATA;
                O_TLAST   = I0_TLAST;
                I0_TREADY = O_TREADY;
            end
        end
    end

    always_comb begin
        arb_d   = arb_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (arb_q == ARB_IDLE) begin
            if (I0_TVALID | I1_TVALID) begin
                arb_d   = ARB_BUSY;
                grant_d = winner;
            end
        end else if (O_TVALID & O_TREADY & O_TLAST) begin
            arb_d = ARB_IDLE;
`ifdef ARB_FIXED_PRIORITY_EN
            rr_d  = 1'b0;
`else
            rr_d  = ~grant_q;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Response router
    // ------------------------------------------------------------------
    always_comb begin
        hdr_id = RI_TDATA[55:48];
        hit0   = (hdr_id == SRC_ID0);
        hit1   = (hdr_id == SRC_ID1);
        case (rsp_q)
            RSP_HDR: begin
                route_en  = hit0 | hit1;
                route_sel = ~hit0;       // port 0 wins when both IDs match
            end
            RSP_PASS: begin
                route_en  = 1'b1;
                route_sel = rsel_q;
            end
            default: begin
                route_en  = 1'b0;
                route_sel = 1'b0;
            end
        endcase
    end

    always_comb begin
        R0_TVALID = route_en & ~route_sel & RI_TVALID;
        R0_TDATA  = (route_en & ~route_sel) ? RI_TDATA : '0;
        R0_TLAST  = route_en & ~route_sel & RI_TLAST;
        R1_TVALID = route_en & route_sel & RI_TVALID;
        R1_TDATA  = (route_en & route_sel) ? RI_TDATA : '0;
        R1_TLAST  = route_en & route_sel & RI_TLAST;
        RI_TREADY = route_en ? (route_sel ? R1_TREADY : R0_TREADY) : 1'b1;
    end

    assign rsp_hs = RI_TVALID & RI_TREADY;

    always_comb begin
        rsp_d  = rsp_q;
        rsel_d = rsel_q;
        bad_d  = bad_q | ((rsp_q == RSP_HDR) & RI_TVALID & ~route_en);
        case (rsp_q)
            RSP_HDR: begin
                // Single-beat packets (TLAST on the header) stay in RSP_HDR.
                if (rsp_hs & ~RI_TLAST) begin
                    if (route_en) begin
                        rsp_d  = RSP_PASS;
                        rsel_d = route_sel;
                    end else begin
                        rsp_d  = RSP_DROP;
                    end
                end
            end
            RSP_PASS, RSP_DROP: begin
                if (rsp_hs & RI_TLAST) rsp_d = RSP_HDR;
            end
            default: rsp_d = RSP_HDR;
        endcase
    end

    assign bad_id = bad_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_q   <= ARB_IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            rsp_q   <= RSP_HDR;
            rsel_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            arb_q   <= arb_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            rsp_q   <= rsp_d;
            rsel_q  <= rsel_d;
            bad_q   <= bad_d;
        end
    end

endmodule

// File: tb/tb_m_req_arb2.sv
module tb_m_req_arb2;

    localparam logic [7:0] P_ID0 = 8'h00;
    localparam logic [7:0] P_ID1 = 8'h01;

    logic        clk, reset;
    logic        I0_TVALID, I0_TREADY, I0_TLAST;
    logic [63:0] I0_TDATA;
    logic        I1_TVALID, I1_TREADY, I1_TLAST;
    logic [63:0] I1_TDATA;
    logic        O_TVALID, O_TREADY, O_TLAST;
    logic [63:0] O_TDATA;
    logic        RI_TVALID, RI_TREADY, RI_TLAST;
    logic [63:0] RI_TDATA;
    logic        R0_TVALID, R0_TREADY, R0_TLAST;
    logic [63:0] R0_TDATA;
    logic        R1_TVALID, R1_TREADY, R1_TLAST;
    logic [63:0] R1_TDATA;
    logic        bad_id;

    int checks = 0;
    int errors = 0;

    m_req_arb2 #(.SRC_ID0(P_ID0), .SRC_ID1(P_ID1)) dut (
        .clk(clk), .reset(reset),
        .I0_TVALID(I0_TVALID), .I0_TREADY(I0_TREADY), .I0_TDATA(I0_TDATA), .I0_TLAST(I0_TLAST),
        .I1_TVALID(I1_TVALID), .I1_TREADY(I1_TREADY), .I1_TDATA(I1_TDATA), .I1_TLAST(I1_TLAST),
        .O_TVALID(O_TVALID), .O_TREADY(O_TREADY), .O_TDATA(O_TDATA), .O_TLAST(O_TLAST),
        .RI_TVALID(RI_TVALID), .RI_TREADY(RI_TREADY), .RI_TDATA(RI_TDATA), .RI_TLAST(RI_TLAST),
        .R0_TVALID(R0_TVALID), .R0_TREADY(R0_TREADY), .R0_TDATA(R0_TDATA), .R0_TLAST(R0_TLAST),
        .R1_TVALID(R1_TVALID), .R1_TREADY(R1_TREADY), .R1_TDATA(R1_TDATA), .R1_TLAST(R1_TLAST),
        .bad_id(bad_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: packet ownership and response routing as plain integers.
    int m_busy, m_gnt, m_rr, m_rsp, m_rsel, m_bad;  // m_rsp: 0 header, 1 pass, 2 drop
    bit rec = 1'b0;
    int gq[$];

    always @(negedge clk) begin : model
        int tgt, win;
        logic [7:0] id;
        logic e_ov, e_ol, e_ir0, e_ir1, e_rir;
        logic [63:0] e_od;
        if (!reset) begin
            m_busy = 0; m_gnt = 0; m_rr = 0; m_rsp = 0; m_rsel = 0; m_bad = 0;
        end
        e_ov = 1'b0; e_ol = 1'b0; e_od = '0; e_ir0 = 1'b0; e_ir1 = 1'b0;
        if (m_busy != 0) begin
            e_ov  = (m_gnt == 1) ? I1_TVALID : I0_TVALID;
            e_ol  = (m_gnt == 1) ? I1_TLAST  : I0_TLAST;
            e_od  = (m_gnt == 1) ? I1_TDATA  : I0_TDATA;
            e_ir0 = (m_gnt == 0) && O_TREADY;
            e_ir1 = (m_gnt == 1) && O_TREADY;
        end
        id = RI_TDATA[55:48];
        if (m_rsp == 0)      tgt = (id == P_ID0) ? 0 : ((id == P_ID1) ? 1 : -1);
        else if (m_rsp == 1) tgt = m_rsel;
        else                 tgt = -1;
        e_rir = (tgt < 0) ? 1'b1 : ((tgt == 0) ? R0_TREADY : R1_TREADY);

        chk("mdl_o_tvalid", 64'(O_TVALID), 64'(e_ov));
        chk("mdl_o_tdata",  O_TDATA, e_od);
        chk("mdl_o_tlast",  64'(O_TLAST), 64'(e_ol));
        chk("mdl_i0_tready", 64'(I0_TREADY), 64'(e_ir0));
        chk("mdl_i1_tready", 64'(I1_TREADY), 64'(e_ir1));
        chk("mdl_ri_tready", 64'(RI_TREADY), 64'(e_rir));
        chk("mdl_r0_tvalid", 64'(R0_TVALID), 64'((tgt == 0) && RI_TVALID));
        chk("mdl_r0_tdata",  R0_TDATA, (tgt == 0) ? RI_TDATA : 64'h0);
        chk("mdl_r0_tlast",  64'(R0_TLAST), 64'((tgt == 0) && RI_TLAST));
        chk("mdl_r1_tvalid", 64'(R1_TVALID), 64'((tgt == 1) && RI_TVALID));
        chk("mdl_r1_tdata",  R1_TDATA, (tgt == 1) ? RI_TDATA : 64'h0);
        chk("mdl_r1_tlast",  64'(R1_TLAST), 64'((tgt == 1) && RI_TLAST));
        chk("mdl_bad_id",    64'(bad_id), 64'(m_bad));

        if (rec && O_TVALID && O_TREADY) gq.push_back(I1_TREADY ? 1 : 0);

        if (reset) begin
            if (m_busy == 0) begin
                if (I0_TVALID || I1_TVALID) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    win = I0_TVALID ? 0 : 1;
`else
                    win = ((m_rr == 0) ? I0_TVALID : I1_TVALID) ? m_rr : 1 - m_rr;
`endif
                    m_busy = 1;
                    m_gnt  = win;
                end
            end else if (e_ov && O_TREADY && e_ol) begin
                m_busy = 0;
`ifdef ARB_FIXED_PRIORITY_EN
                m_rr = 0;
`else
                m_rr = 1 - m_gnt;
`endif
            end
            if (m_rsp == 0) begin
                if (RI_TVALID && tgt < 0) m_bad = 1;
                if (RI_TVALID && e_rir && !RI_TLAST) begin
                    if (tgt < 0) m_rsp = 2;
                    else begin m_rsp = 1; m_rsel = tgt; end
                end
            end else if (RI_TVALID && e_rir && RI_TLAST) begin
                m_rsp = 0;
            end
        end
    end

    initial begin : stim
        logic [63:0] oq[$];
        logic [63:0] rq[$];
        logic [63:0] tmp;
        int k, j, viol, r0seen;

        reset = 1'b0;
        I0_TVALID = 0; I0_TDATA = '0; I0_TLAST = 0;
        I1_TVALID = 0; I1_TDATA = '0; I1_TLAST = 0;
        O_TREADY = 0;
        RI_TVALID = 0; RI_TDATA = '0; RI_TLAST = 0;
        R0_TREADY = 0; R1_TREADY = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_tvalid", 64'(O_TVALID), 64'h0);
        chk("rst_o_tdata", O_TDATA, 64'h0);
        chk("rst_i0_tready", 64'(I0_TREADY), 64'h0);
        chk("rst_i1_tready", 64'(I1_TREADY), 64'h0);
        chk("rst_r0_tvalid", 64'(R0_TVALID), 64'h0);
        chk("rst_bad_id", 64'(bad_id), 64'h0);
        @(posedge clk); #1 reset = 1'b1;

        // Both ports stream single-beat packets: grants must alternate.
        @(posedge clk); #1;
        I0_TVALID = 1; I0_TLAST = 1; I0_TDATA = 64'h10;
        I1_TVALID = 1; I1_TLAST = 1; I1_TDATA = 64'h11;
        O_TREADY = 1; rec = 1'b1;
        repeat (8) @(posedge clk);
        #1 rec = 1'b0; I0_TVALID = 0; I1_TVALID = 0; I0_TLAST = 0; I1_TLAST = 0;
        chk("t2_count", 64'(gq.size()), 64'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            chk("t2_grant", 64'(gq[i]), 64'd0);
`else
            chk("t2_grant", 64'(gq[i]), 64'(i % 2));
`endif
        end

        // I0 alone sends a 3-beat write.
        @(posedge clk); #1;
        I0_TVALID = 1; I0_TDATA = 64'h1f000000_00010000; I0_TLAST = 0; O_TREADY = 1;
        @(negedge clk); chk("t1_latency", 64'(O_TVALID), 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_ovalid", 64'(O_TVALID), 64'h1);
        chk("t1_hdr", O_TDATA, 64'h1f000000_00010000);
        chk("t1_i1_tready", 64'(I1_TREADY), 64'h0);
        @(posedge clk); #1 I0_TDATA = 64'hD0;
        @(negedge clk); chk("t1_d0", O_TDATA, 64'hD0);
        @(posedge clk); #1 I0_TDATA = 64'hD1; I0_TLAST = 1;
        @(negedge clk); chk("t1_d1", O_TDATA, 64'hD1); chk("t1_last", 64'(O_TLAST), 64'h1);
        @(posedge clk); #1 I0_TVALID = 0; I0_TLAST = 0;
        @(negedge clk); chk("t1_idle", 64'(O_TVALID), 64'h0);

        // I1 granted, O_TREADY toggling during a 4-beat packet, I0 waiting.
        @(posedge clk); #1 I1_TVALID = 1; I1_TDATA = 64'hB0; I1_TLAST = 0; O_TREADY = 1;
        @(posedge clk); #1 I0_TVALID = 1; I0_TLAST = 1; I0_TDATA = 64'hC0;
        k = 0; viol = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            O_TREADY = (c % 2 == 0);
            I1_TDATA = 64'hB0 + 64'(k);
            I1_TLAST = (k == 3);
            @(negedge clk);
            if (I0_TREADY) viol++;
            if (O_TVALID && O_TREADY) begin oq.push_back(O_TDATA); k++; end
            @(posedge clk); #1;
        end
        I1_TVALID = 0; I1_TLAST = 0; O_TREADY = 1;
        chk("t3_beats", 64'(oq.size()), 64'd4);
        for (int i = 0; i < 4 && i < oq.size(); i++) chk("t3_data", oq[i], 64'hB0 + 64'(i));
        chk("t3_i0_blocked", 64'(viol), 64'd0);
        @(negedge clk); chk("t3_gap", 64'(I0_TREADY), 64'h0);
        @(posedge clk); #1;
        @(negedge clk); chk("t3_i0_next", 64'(I0_TREADY), 64'h1);
        @(posedge clk); #1 I0_TVALID = 0; I0_TLAST = 0;

        // Response for SRC_ID1 with R1 stalling two cycles.
        R0_TREADY = 1; R1_TREADY = 1; j = 0; r0seen = 0;
        for (int c = 0; c < 20 && j < 4; c++) begin
            RI_TVALID = 1;
            RI_TDATA  = (j == 0) ? 64'h00010000_00000000 : 64'hA0 + 64'(j);
            RI_TLAST  = (j == 3);
            R1_TREADY = !(c == 1 || c == 2);
            @(negedge clk);
            if (R0_TVALID) r0seen++;
            if (RI_TVALID && RI_TREADY) begin
                if (R1_TVALID) rq.push_back(R1_TDATA);
                j++;
            end
            @(posedge clk); #1;
        end
        RI_TVALID = 0; RI_TLAST = 0; R1_TREADY = 1;
        chk("t4_beats", 64'(rq.size()), 64'd4);
        if (rq.size() == 4) begin
            chk("t4_hdr", rq[0], 64'h00010000_00000000);
            for (int i = 1; i < 4; i++) chk("t4_data", rq[i], 64'hA0 + 64'(i));
        end
        chk("t4_r0_quiet", 64'(r0seen), 64'd0);

        // Unknown ID 8'h7e: dropped, bad_id set; then a WRACK for SRC_ID0.
        @(negedge clk); chk("t5_bad_pre", 64'(bad_id), 64'h0);
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            RI_TVALID = 1;
            RI_TDATA  = (c == 0) ? 64'h007e0000_00000000 : 64'hE0 + 64'(c);
            RI_TLAST  = (c == 2);
            @(negedge clk);
            chk("t5_ri_tready", 64'(RI_TREADY), 64'h1);
            chk("t5_no_r0", 64'(R0_TVALID), 64'h0);
            chk("t5_no_r1", 64'(R1_TVALID), 64'h0);
            @(posedge clk); #1;
        end
        RI_TVALID = 0; RI_TLAST = 0;
        @(negedge clk); chk("t5_bad_id", 64'(bad_id), 64'h1);
        @(posedge clk); #1 RI_TVALID = 1; RI_TDATA = 64'h00000000_0000beef; RI_TLAST = 1;
        @(negedge clk);
        chk("t5_wrack_v", 64'(R0_TVALID), 64'h1);
        chk("t5_wrack_d", R0_TDATA, 64'h00000000_0000beef);
        chk("t5_wrack_r1", 64'(R1_TVALID), 64'h0);
        @(posedge clk); #1 RI_TVALID = 0; RI_TLAST = 0;

        // Reset in the middle of a 5-beat request.
        @(posedge clk); #1 I0_TVALID = 1; I0_TDATA = 64'h50; I0_TLAST = 0; O_TREADY = 1;
        repeat (3) @(posedge clk);
        #1 chk("t6_pre", 64'(O_TVALID), 64'h1);
        #2 reset = 1'b0;
        #1 chk("t6_ovalid", 64'(O_TVALID), 64'h0);
        chk("t6_i0_tready", 64'(I0_TREADY), 64'h0);
        chk("t6_bad_clr", 64'(bad_id), 64'h0);
        I0_TVALID = 0;
        @(posedge clk); #1 reset = 1'b1; I1_TVALID = 1; I1_TLAST = 1; I1_TDATA = 64'h61;
        @(negedge clk); chk("t6_idle", 64'(O_TVALID), 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_i1_grant", 64'(I1_TREADY), 64'h1);
        chk("t6_i1_data", O_TDATA, 64'h61);
        @(posedge clk); #1 I1_TVALID = 0; I1_TLAST = 0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 199) != 0);
            I0_TVALID = ($urandom_range(0, 9) < 7);
            I0_TDATA  = {$urandom, $urandom};
            I0_TLAST  = ($urandom_range(0, 9) < 3);
            I1_TVALID = ($urandom_range(0, 9) < 7);
            I1_TDATA  = {$urandom, $urandom};
            I1_TLAST  = ($urandom_range(0, 9) < 3);
            O_TREADY  = ($urandom_range(0, 9) < 7);
            RI_TVALID = ($urandom_range(0, 9) < 7);
            RI_TLAST  = ($urandom_range(0, 9) < 3);
            R0_TREADY = ($urandom_range(0, 9) < 7);
            R1_TREADY = ($urandom_range(0, 9) < 7);
            tmp = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: tmp[55:48] = P_ID0;
                1: tmp[55:48] = P_ID1;
                2: tmp[55:48] = 8'h7e;
                default: ;
            endcase
            RI_TDATA = tmp;
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
